// File: rtl/axi_ring_wr_master.sv
// AXI4 write master that walks a ring buffer [cfg_beg_addr, cfg_end_addr) fed from a
// show-ahead FIFO. Bursts that would cross a 4 KB page are split into two transactions.
module axi_ring_wr_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 30,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   cfg_beg_addr,
    input  logic [ADDR_WIDTH-1:0]   cfg_end_addr,
    input  logic [7:0]              cfg_burst_len,
    input  logic                    ring_rst,
    input  logic                    wr_start,
    output logic                    wr_ready,
    output logic                    wr_busy,
    output logic                    wr_done,
    output logic                    wr_err,
    output logic [ADDR_WIDTH-1:0]   cur_addr,
    input  logic [DATA_WIDTH-1:0]   fifo_data,
    input  logic                    fifo_valid,
    output logic                    fifo_ack,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] base;
    logic [8:0]            remaining;
    logic [7:0]            awlen_q;
    logic [7:0]            beat_cnt;
    logic                  w_hs;
    logic [8:0]            rem_start;
    logic [8:0]            sub_beats;
    logic [8:0]            rem_nx;
    logic [ADDR_WIDTH:0]   req_bytes;
    logic [ADDR_WIDTH:0]   req_end;
    logic [ADDR_WIDTH-1:0] start_base;
    logic [ADDR_WIDTH-1:0] base_nx;
    logic                  unused_bid;

    // Beats left in the current 4 KB page from b, capped by the beats still owed.
    function automatic logic [7:0] calc_len(input logic [ADDR_WIDTH-1:0] b,
                                            input logic [8:0]            rem);
        logic [12:0] room;
        room = (13'd4096 - {1'b0, b[11:0]}) >> SIZE;
        if ({4'd0, rem} > room) calc_len = 8'(room - 13'd1);
        else                    calc_len = 8'(rem - 9'd1);
    endfunction

    assign rem_start  = {1'b0, cfg_burst_len} + 9'd1;
    assign req_bytes  = ({{(ADDR_WIDTH-7){1'b0}}, cfg_burst_len} + (ADDR_WIDTH+1)'(1)) << SIZE;
    assign req_end    = {1'b0, cur_addr} + req_bytes;
    assign start_base = (req_end > {1'b0, cfg_end_addr}) ? cfg_beg_addr : cur_addr;
    assign sub_beats  = {1'b0, awlen_q} + 9'd1;
    assign rem_nx     = remaining - sub_beats;
    assign base_nx    = base + (ADDR_WIDTH'(sub_beats) << SIZE);

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = base;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = fifo_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = m_axi_wvalid && (beat_cnt == awlen_q);
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign fifo_ack      = w_hs;
    assign wr_ready      = (state == S_IDLE);
    assign wr_busy       = (state != S_IDLE);
    assign unused_bid    = ^m_axi_bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nx      = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            S_IDLE: if (wr_start && !ring_rst) state_nx = S_AW;
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nx = S_W;
            end
            S_W: begin
                m_axi_wvalid = fifo_valid;
                if (fifo_valid && m_axi_wready && (beat_cnt == awlen_q)) state_nx = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nx = (rem_nx != 9'd0) ? S_AW : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            base      <= '0;
            remaining <= '0;
            awlen_q   <= '0;
            beat_cnt  <= '0;
            wr_err    <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            wr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ring_rst) begin
                        cur_addr <= cfg_beg_addr;
                        wr_err   <= 1'b0;
                    end else if (wr_start) begin
                        base      <= start_base;
                        remaining <= rem_start;
                        awlen_q   <= calc_len(start_base, rem_start);
                        beat_cnt  <= '0;
                    end
                end
                S_W: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
                S_B: begin
                    if (m_axi_bvalid) begin
                        wr_err    <= wr_err | (m_axi_bresp != 2'b00);
                        remaining <= rem_nx;
                        base      <= base_nx;
                        if (rem_nx != 9'd0) begin
                            awlen_q  <= calc_len(base_nx, rem_nx);
                            beat_cnt <= '0;
                        end else begin
                            cur_addr <= base_nx;
                            wr_done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ring_wr_master.sv
// Directed bench for axi_ring_wr_master: a bench-side AXI slave and FIFO model plus
// per-scenario tasks with hand-computed expectations.
module tb_axi_ring_wr_master;
    localparam int DW = 64;
    localparam int AW = 30;
    localparam int IW = 4;
    localparam int ID = 5;
    localparam logic [63:0] DBASE = 64'hD00D_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cfg_beg_addr, cfg_end_addr, cur_addr;
    logic [7:0]    cfg_burst_len;
    logic          ring_rst, wr_start, wr_ready, wr_busy, wr_done, wr_err;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid, fifo_ack;
    logic [IW-1:0] m_axi_awid, m_axi_bid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize, m_axi_awprot;
    logic [1:0]    m_axi_awburst, m_axi_bresp;
    logic          m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [3:0]    m_axi_awcache, m_axi_awqos;
    logic [DW-1:0] m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready;

    int vectors = 0;
    int miscompares = 0;

    // Slave / FIFO policy and capture state.
    int          aw_stall = 0;
    bit          w_toggle = 0;
    bit          gap_en = 0;
    logic [1:0]  bresp_q[$];
    logic [AW-1:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [7:0]  w_len_q[$];
    int aw_wait = 0, aw_hold = 0, w_beat = 0, b_pend = 0, cyc = 0, pop_cnt = 0;
    int w_cnt = 0, last_cnt = 0, b_cnt = 0, done_cnt = 0, ack_cnt = 0;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;

    axi_ring_wr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(ID)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_beg_addr(cfg_beg_addr), .cfg_end_addr(cfg_end_addr), .cfg_burst_len(cfg_burst_len),
        .ring_rst(ring_rst), .wr_start(wr_start), .wr_ready(wr_ready), .wr_busy(wr_busy),
        .wr_done(wr_done), .wr_err(wr_err), .cur_addr(cur_addr),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ack(fifo_ack),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    // Slave and FIFO: drive at the falling edge, observe 1 ns later; each observed
    // handshake takes effect on the following rising edge.
    initial begin : slave
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = IW'(ID); fifo_valid = 1'b0; fifo_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_stall);
            m_axi_wready  = w_toggle ? cyc[0] : 1'b1;
            fifo_valid    = !(gap_en && (cyc % 3 == 2));
            fifo_data     = DBASE + 64'(pop_cnt);
            m_axi_bvalid  = (b_pend > 0);
            m_axi_bresp   = (b_pend > 0 && bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
            #1;
            if (!rst_n) continue;
            if (m_axi_awvalid) begin
                if (aw_wait > 0) begin
                    vectors++;
                    if (m_axi_awaddr !== hold_addr || m_axi_awlen !== hold_len) begin
                        miscompares++;
                        $display("FAIL aw_stable: awaddr=%h awlen=%0d, held %h/%0d",
                                 m_axi_awaddr, m_axi_awlen, hold_addr, hold_len);
                    end
                end
                hold_addr = m_axi_awaddr;
                hold_len  = m_axi_awlen;
                if (m_axi_awready) begin
                    aw_addr_q.push_back(m_axi_awaddr);
                    aw_len_q.push_back(m_axi_awlen);
                    w_len_q.push_back(m_axi_awlen);
                    aw_hold = aw_wait + 1;
                    aw_wait = 0;
                end else aw_wait++;
            end
            if (m_axi_wvalid || fifo_ack) begin
                vectors++;
                if (fifo_ack !== (m_axi_wvalid & m_axi_wready) || w_len_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL w_ctrl: fifo_ack=%b wvalid=%b wready=%b open_aw=%0d",
                             fifo_ack, m_axi_wvalid, m_axi_wready, w_len_q.size());
                end
            end
            if (fifo_ack) ack_cnt++;
            if (m_axi_wvalid && m_axi_wready) begin
                vectors++;
                if (m_axi_wdata !== DBASE + 64'(pop_cnt)) begin
                    miscompares++;
                    $display("FAIL wdata: got %h want %h", m_axi_wdata, DBASE + 64'(pop_cnt));
                end
                vectors++;
                if (m_axi_wlast !== (w_len_q.size() > 0 && w_beat == int'(w_len_q[0]))) begin
                    miscompares++;
                    $display("FAIL wlast: got %b at beat %0d", m_axi_wlast, w_beat);
                end
                pop_cnt++;
                w_cnt++;
                if (m_axi_wlast) begin
                    last_cnt++;
                    b_pend++;
                    w_beat = 0;
                    if (w_len_q.size() > 0) void'(w_len_q.pop_front());
                end else w_beat++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend--;
                b_cnt++;
                if (bresp_q.size() > 0) void'(bresp_q.pop_front());
            end
            if (wr_done) done_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic ring_reset(input logic [AW-1:0] beg, input logic [AW-1:0] fin);
        cfg_beg_addr = beg;
        cfg_end_addr = fin;
        ring_rst = 1'b1;
        step();
        ring_rst = 1'b0;
    endtask

    // Issues one user request and waits (bounded) for its wr_done pulse.
    task automatic run_req(input logic [7:0] len);
        aw_addr_q.delete(); aw_len_q.delete();
        w_cnt = 0; last_cnt = 0; b_cnt = 0; done_cnt = 0; ack_cnt = 0;
        cfg_burst_len = len;
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        vectors++;
        if (m_axi_awvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL start_latency: awvalid=%b want 1", m_axi_awvalid);
        end
        for (int k = 0; k < 1000 && wr_done !== 1'b1; k++) step();
        vectors++;
        if (wr_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: wr_done=%b want 1", wr_done);
        end
        step();
        vectors++;
        if (wr_done !== 1'b0 || wr_ready !== 1'b1 || wr_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b ready=%b busy=%b want 0/1/0", wr_done, wr_ready, wr_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ring_rst = 1'b0; wr_start = 1'b0;
        cfg_beg_addr = '0; cfg_end_addr = '0; cfg_burst_len = '0;
        step(); step();
        vectors++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0 ||
            fifo_ack !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0 ||
            wr_ready !== 1'b1 || wr_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: awv=%b wv=%b br=%b ack=%b done=%b err=%b rdy=%b busy=%b",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, fifo_ack, wr_done, wr_err, wr_ready, wr_busy);
        end
        vectors++;
        if (cur_addr !== '0 || m_axi_awaddr !== '0 || m_axi_awlen !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_addr: cur=%h awaddr=%h awlen=%0d want 0", cur_addr, m_axi_awaddr, m_axi_awlen);
        end
        vectors++;
        if (m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01 || m_axi_awlock !== 1'b0 ||
            m_axi_awcache !== 4'b0010 || m_axi_awprot !== 3'd0 || m_axi_awqos !== 4'd0 ||
            m_axi_wstrb !== 8'hFF || m_axi_awid !== 4'd5) begin
            miscompares++;
            $display("FAIL const_fields: size=%0d burst=%b cache=%b strb=%h id=%0d",
                     m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb, m_axi_awid);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        ring_reset(30'h0, 30'h10000);
        run_req(8'd15);
        vectors++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 30'h0 || aw_len_q[0] !== 8'd15) begin
            miscompares++;
            $display("FAIL single_aw: n=%0d addr=%h len=%0d want 1/0/15", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]);
        end
        vectors++;
        if (w_cnt != 16 || last_cnt != 1 || done_cnt != 1 || cur_addr !== 30'h80) begin
            miscompares++;
            $display("FAIL single_end: beats=%0d lasts=%0d dones=%0d cur=%h want 16/1/1/80",
                     w_cnt, last_cnt, done_cnt, cur_addr);
        end
    endtask

    task automatic test_split();
        ring_reset(30'h0FC0, 30'h10000);
        run_req(8'd15);
        vectors++;
        if (aw_addr_q.size() != 2 || aw_addr_q[0] !== 30'h0FC0 || aw_len_q[0] !== 8'd7 ||
            aw_addr_q[1] !== 30'h1000 || aw_len_q[1] !== 8'd7) begin
            miscompares++;
            $display("FAIL split_aw: n=%0d %h/%0d %h/%0d want 0fc0/7 1000/7",
                     aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        vectors++;
        if (b_cnt != 2 || done_cnt != 1 || last_cnt != 2 || w_cnt != 16 || cur_addr !== 30'h1040) begin
            miscompares++;
            $display("FAIL split_end: b=%0d dones=%0d lasts=%0d beats=%0d cur=%h want 2/1/2/16/1040",
                     b_cnt, done_cnt, last_cnt, w_cnt, cur_addr);
        end
    endtask

    task automatic test_wrap();
        ring_reset(30'h0F80, 30'h1000);
        cfg_beg_addr = 30'h0;
        run_req(8'd15);
        vectors++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 30'h0F80 || aw_len_q[0] !== 8'd15 || cur_addr !== 30'h1000) begin
            miscompares++;
            $display("FAIL wrap_first: n=%0d addr=%h len=%0d cur=%h want 1/f80/15/1000",
                     aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], cur_addr);
        end
        run_req(8'd15);
        vectors++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 30'h0 || aw_len_q[0] !== 8'd15 || cur_addr !== 30'h80) begin
            miscompares++;
            $display("FAIL wrap_second: n=%0d addr=%h len=%0d cur=%h want 1/0/15/80",
                     aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], cur_addr);
        end
    endtask

    task automatic test_backpressure();
        ring_reset(30'h0, 30'h10000);
        aw_stall = 5; w_toggle = 1; gap_en = 1;
        run_req(8'd15);
        aw_stall = 0; w_toggle = 0; gap_en = 0;
        vectors++;
        if (aw_hold != 6 || aw_addr_q.size() != 1 || aw_addr_q[0] !== 30'h0 || aw_len_q[0] !== 8'd15) begin
            miscompares++;
            $display("FAIL bp_aw: hold=%0d n=%0d addr=%h len=%0d want 6/1/0/15",
                     aw_hold, aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]);
        end
        vectors++;
        if (ack_cnt != 16 || w_cnt != 16 || last_cnt != 1 || cur_addr !== 30'h80) begin
            miscompares++;
            $display("FAIL bp_w: acks=%0d beats=%0d lasts=%0d cur=%h want 16/16/1/80",
                     ack_cnt, w_cnt, last_cnt, cur_addr);
        end
    endtask

    task automatic test_error();
        ring_reset(30'h0FC0, 30'h10000);
        bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00);
        run_req(8'd15);
        vectors++;
        if (wr_err !== 1'b1 || aw_addr_q.size() != 2 || aw_addr_q[1] !== 30'h1000 ||
            done_cnt != 1 || cur_addr !== 30'h1040) begin
            miscompares++;
            $display("FAIL err_req: err=%b n=%0d aw1=%h dones=%0d cur=%h want 1/2/1000/1/1040",
                     wr_err, aw_addr_q.size(), aw_addr_q[1], done_cnt, cur_addr);
        end
        cfg_beg_addr = 30'h200;
        ring_rst = 1'b1;
        wr_start = 1'b1;
        step();
        ring_rst = 1'b0;
        wr_start = 1'b0;
        vectors++;
        if (wr_err !== 1'b0 || cur_addr !== 30'h200 || m_axi_awvalid !== 1'b0 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_clear: err=%b cur=%h awv=%b rdy=%b want 0/200/0/1",
                     wr_err, cur_addr, m_axi_awvalid, wr_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        ring_reset(30'h400, 30'h10000);
        w_cnt = 0;
        cfg_burst_len = 8'd15;
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        for (int k = 0; k < 200 && w_cnt < 5; k++) step();
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || fifo_ack !== 1'b0 || m_axi_bready !== 1'b0 ||
            wr_done !== 1'b0 || wr_ready !== 1'b1 || wr_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: awv=%b wv=%b ack=%b br=%b done=%b rdy=%b busy=%b",
                     m_axi_awvalid, m_axi_wvalid, fifo_ack, m_axi_bready, wr_done, wr_ready, wr_busy);
        end
        vectors++;
        if (cur_addr !== '0 || m_axi_awaddr !== '0 || m_axi_awlen !== 8'd0 || wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_regs: cur=%h awaddr=%h awlen=%0d err=%b want 0",
                     cur_addr, m_axi_awaddr, m_axi_awlen, wr_err);
        end
        step(); step();
        rst_n = 1'b1;
        w_len_q.delete();
        b_pend = 0; w_beat = 0; aw_wait = 0;
        step();
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_ready: wr_ready=%b want 1", wr_ready);
        end
        run_req(8'd3);
        vectors++;
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 30'h0 || aw_len_q[0] !== 8'd3 ||
            w_cnt != 4 || cur_addr !== 30'h20) begin
            miscompares++;
            $display("FAIL post_reset_req: n=%0d addr=%h len=%0d beats=%0d cur=%h want 1/0/3/4/20",
                     aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], w_cnt, cur_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_wrap();
        test_backpressure();
        test_error();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_ring_wr_master.md
Name: axi_ring_wr_master

Overview:
Parametrised single-clock AXI4 write master that succeeds the fixed 64-bit write master used under the DDR controller top.
- Adds configurable data, address and ID widths.
- Walks a ring buffer [cfg_beg_addr, cfg_end_addr) automatically.
- Splits any burst that would cross a 4 KB boundary into two AXI transactions.
- Reports BRESP errors through a sticky flag.
- Sits between the user-side write FIFO (show-ahead read port) and the DDR AXI slave port.

Parameters:
DATA_WIDTH, 64, AXI data width in bits; power of two, 32..512.
ADDR_WIDTH, 30, byte address width.
ID_WIDTH, 4, AXI ID width.
AXI_ID, 0, constant value driven on m_axi_awid.

Ports:
clk  in  1  AXI clock
rst_n  in  1  asynchronous active-low reset
cfg_beg_addr  in  ADDR_WIDTH  ring start address, aligned to DATA_WIDTH/8
cfg_end_addr  in  ADDR_WIDTH  ring end address, exclusive
cfg_burst_len  in  8  beats-1 per user request
ring_rst  in  1  pulse: reload cur_addr from cfg_beg_addr
wr_start  in  1  pulse: issue one user request; honoured only while wr_ready=1
wr_ready  out  1  high in IDLE
wr_busy  out  1  high outside IDLE
wr_done  out  1  one-cycle pulse when the whole user request has completed
wr_err  out  1  sticky: some BRESP was non-zero; cleared by ring_rst
cur_addr  out  ADDR_WIDTH  next ring write address
fifo_data  in  DATA_WIDTH  show-ahead write-FIFO data
fifo_valid  in  1  FIFO not empty
fifo_ack  out  1  pop strobe, equal to the W-channel handshake
m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  out  std AXI4 widths
m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH
m_axi_wstrb  out  DATA_WIDTH/8
m_axi_wlast, m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bid  in  ID_WIDTH
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; all valid/ack/done outputs 0; wr_err 0.
  - cur_addr = 0; awaddr 0; awlen 0.
  - wr_ready 1; wr_busy 0.
- Constant AXI fields:
  - awsize = log2(DATA_WIDTH/8); awburst = 2'b01 (INCR).
  - awlock 0; awcache 4'b0010; awprot 0; awqos 0.
  - wstrb all ones; awid = AXI_ID.
- Terminology: B = DATA_WIDTH/8 bytes per beat; N = cfg_burst_len+1 beats; bytes = N*B.
- IDLE:
  - ring_rst → cur_addr ← cfg_beg_addr and wr_err ← 0. ring_rst has priority over wr_start in the same cycle; the start is dropped.
  - wr_start → latch N. Base address selection:
    - If cur_addr + bytes > cfg_end_addr, base ← cfg_beg_addr (wrap).
    - Otherwise base ← cur_addr.
    - Compare at ADDR_WIDTH+1 bits so the sum cannot overflow.
  - Then go to AW.
- AW: sub-burst length split at the 4 KB boundary.
  - room = (4096 − base[11:0]) / B beats.
  - If remaining beats > room, awlen = room−1; otherwise awlen = remaining−1.
  - awvalid rises on entry and holds, with all AW fields stable, until awready; then go to W.
- W: data beats.
  - wvalid = fifo_valid; wdata = fifo_data; handshake = wvalid & wready; fifo_ack = handshake.
  - The beat counter increments on each handshake.
  - wlast = (count == awlen) while wvalid is high.
  - A handshake with wlast set → B.
  - W never asserts before the AW handshake has completed.
- B:
  - bready = 1.
  - On bvalid: wr_err |= (bresp != 0); remaining −= awlen+1; base += (awlen+1)*B.
  - If remaining > 0, go to AW (second split transaction).
  - Else: cur_addr ← base, pulse wr_done for 1 cycle, go to IDLE. wr_ready is high on the next cycle.
- Latency: wr_start to awvalid = 1 cycle.
- Ignored inputs:
  - wr_start outside IDLE is ignored.
  - ring_rst outside IDLE is ignored.
  - cfg_* are sampled only on the wr_start cycle.
- FIFO empty mid-burst: wvalid drops and the beat is stalled. No timeout.
- Reset mid-burst: immediate return to reset values. Outstanding AXI state is the slave's responsibility.
- Error recovery: a BRESP error does not abort the request; the remaining sub-burst is still issued.
- Legal configuration: bytes ≤ cfg_end_addr − cfg_beg_addr. Anything else is undefined; the block does not check it.

Test Plan:
1. DATA_WIDTH=64, beg=0x0, end=0x10000, cur=0x0, len=15, wr_start, ready slave → one AW with awaddr=0x0 and awlen=15; 16 beats with wlast on beat 16; wr_done pulse; cur_addr=0x80.
2. 4 KB split: cur=0x0FC0, len=15 → AW0 at 0x0FC0 with awlen=7, B, then AW1 at 0x1000 with awlen=7; wr_done only after the second B; cur_addr=0x1040.
3. Ring wrap: beg=0x0, end=0x1000, cur=0x0F80, len=15 → burst at 0x0F80 and cur_addr=0x1000; the next wr_start issues awaddr=0x0 and leaves cur_addr=0x80.
4. Backpressure: awready low for 5 cycles and AW fields stay stable; wready toggling 1/0 and fifo_valid gaps → exactly 16 fifo_ack pulses, data in order, wlast only on the final handshake.
5. Error: bresp=2'b10 on the first B of a split request → wr_err=1, second sub-burst still issued, wr_done pulses; a following ring_rst clears wr_err and sets cur_addr=beg.
6. Reset mid-W after 5 beats → all outputs at reset values in the same cycle. After release, wr_ready=1 and a new 4-beat request completes normally.
